// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encoding, key-length codes and Nk/Nr lookups for the AES sequencer
package aes_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, KEY_FETCH, KEY_EXPAND, DATA_FETCH, PREADD, ROUND, WRITE, ERROR} state_t;
  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;
  function automatic int unsigned nk(input logic [1:0] kl);
    return kl == KL_256 ? 8 : kl == KL_192 ? 6 : 4;
  endfunction
  function automatic int unsigned nr(input logic [1:0] kl);
    return nk(kl) + 6;
  endfunction
endpackage

// File: rtl/flex_counter.sv
// flex_counter: loadable up/down counter with synchronous clear
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic         dn_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (ld_i) cnt_q <= ld_val_i;
    else if (en_i) cnt_q <= dn_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: sequences key loading, block fetch, AES rounds and result write-back
module aes_seq_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_received,
  input  logic             data_type,
  input  logic             enc_dec,
  input  logic [1:0]       key_len,
  input  logic             key_done,
  input  logic             out_ready,
  input  logic             stop,
  output logic             opt_mode,
  output logic             load_key,
  output logic             key_shift_en,
  output logic             preaddkey,
  output logic             aes_load,
  output logic             round_en,
  output logic             last_round,
  output logic             ahb_mode,
  output logic             ahb_shift_en,
  output logic             done_chg_key,
  output logic             blk_done,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] round_idx
);
  state_t state_q, state_d;
  logic [1:0] kl_q;
  logic key_valid_q, opt_q, nxt_q;
  logic [CNT_W-1:0] in_cnt, out_cnt, rnd_cnt, nr_c;
  logic df_acc, rd_acc, key_last, in_last, in_en, in_clr, out_en, out_clr, kerr;
  flex_counter #(.W(CNT_W)) u_in_cnt (
    .clk(clk), .rst(rst), .clr_i(in_clr), .ld_i(1'b0), .en_i(in_en), .dn_i(1'b0),
    .ld_val_i('0), .cnt_o(in_cnt)
  );
  flex_counter #(.W(CNT_W)) u_out_cnt (
    .clk(clk), .rst(rst), .clr_i(out_clr), .ld_i(1'b0), .en_i(out_en), .dn_i(1'b0),
    .ld_val_i('0), .cnt_o(out_cnt)
  );
  // round counter holds the round-key index itself: loaded in PREADD with the first round's index
  flex_counter #(.W(CNT_W)) u_rnd_cnt (
    .clk(clk), .rst(rst), .clr_i(state_q == IDLE), .ld_i(preaddkey), .en_i(round_en), .dn_i(opt_q),
    .ld_val_i(enc_dec ? nr_c - 1'b1 : CNT_W'(1)), .cnt_o(rnd_cnt)
  );
  always_comb begin
    nr_c         = CNT_W'(nr(kl_q));
    key_shift_en = state_q == KEY_FETCH && data_received && data_type;
    key_last     = key_shift_en && in_cnt == CNT_W'(nk(kl_q) - 1);
    df_acc       = state_q == DATA_FETCH && data_received && !data_type;
    rd_acc       = state_q == ROUND && data_received && !data_type && !nxt_q;
    in_last      = (df_acc || rd_acc) && in_cnt == CNT_W'(WORDS - 1);
    in_en        = key_shift_en || df_acc || rd_acc;
    in_clr       = state_q == IDLE || key_last || in_last;
    ahb_mode     = state_q == WRITE;
    out_en       = ahb_mode && out_ready;
    ahb_shift_en = df_acc || rd_acc || out_en;
    blk_done     = out_en && out_cnt == CNT_W'(WORDS - 1);
    out_clr      = state_q == IDLE || blk_done;
    load_key     = state_q == KEY_EXPAND && !key_done;
    done_chg_key = state_q == KEY_EXPAND && key_done;
    preaddkey    = state_q == PREADD;
    aes_load     = preaddkey;
    round_en     = state_q == ROUND;
    last_round   = round_en && rnd_cnt == (opt_q ? '0 : nr_c);
    opt_mode     = preaddkey ? enc_dec : opt_q;
    round_idx    = preaddkey ? (enc_dec ? nr_c : '0) : round_en ? rnd_cnt : '0;
    busy         = state_q != IDLE && state_q != ERROR;
    error        = state_q == ERROR;
    kerr         = data_received && (state_q == KEY_FETCH ? !data_type :
                   (state_q == DATA_FETCH || state_q == ROUND) && data_type);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = !start ? IDLE : data_type ? (key_len == KL_BAD ? ERROR : KEY_FETCH) :
                            key_valid_q ? DATA_FETCH : ERROR;
      KEY_FETCH:  state_d = kerr ? ERROR : key_last ? KEY_EXPAND : KEY_FETCH;
      KEY_EXPAND: state_d = key_done ? IDLE : KEY_EXPAND;
      DATA_FETCH: state_d = kerr ? ERROR : in_last ? PREADD :
                            (stop && in_cnt == '0 && !data_received) ? IDLE : DATA_FETCH;
      PREADD:     state_d = ROUND;
      ROUND:      state_d = kerr ? ERROR : last_round ? WRITE : ROUND;
      WRITE:      state_d = blk_done ? (nxt_q ? PREADD : DATA_FETCH) : WRITE;
      ERROR:      state_d = start ? IDLE : ERROR;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kl_q        <= KL_128;
      key_valid_q <= 1'b0;
      opt_q       <= 1'b0;
      nxt_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && data_type && key_len != KL_BAD) kl_q <= key_len;
      if (done_chg_key) key_valid_q <= 1'b1;
      if (preaddkey) opt_q <= enc_dec;
      nxt_q <= (state_q == IDLE || blk_done) ? 1'b0 : (rd_acc && in_last) ? 1'b1 : nxt_q;
    end
  end
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb_aes_seq_ctrl: directed stimulus checked every cycle against a transaction-level model
module tb_aes_seq_ctrl;
  localparam int WORDS = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst, start, data_received, data_type, enc_dec, key_done, out_ready, stop;
  logic [1:0] key_len;
  logic opt_mode, load_key, key_shift_en, preaddkey, aes_load, round_en, last_round;
  logic ahb_mode, ahb_shift_en, done_chg_key, blk_done, busy, error;
  logic [CNT_W-1:0] round_idx;
  logic [12:0] outs;
  always #5 clk = ~clk;
  aes_seq_ctrl #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_received(data_received), .data_type(data_type),
    .enc_dec(enc_dec), .key_len(key_len), .key_done(key_done), .out_ready(out_ready), .stop(stop),
    .opt_mode(opt_mode), .load_key(load_key), .key_shift_en(key_shift_en), .preaddkey(preaddkey),
    .aes_load(aes_load), .round_en(round_en), .last_round(last_round), .ahb_mode(ahb_mode),
    .ahb_shift_en(ahb_shift_en), .done_chg_key(done_chg_key), .blk_done(blk_done), .busy(busy),
    .error(error), .round_idx(round_idx)
  );
  assign outs = {opt_mode, load_key, key_shift_en, preaddkey, aes_load, round_en, last_round,
                 ahb_mode, ahb_shift_en, done_chg_key, blk_done, busy, error};
  int n_cmp = 0, n_bad = 0;
  typedef enum {M_IDLE, M_KF, M_KE, M_DF, M_PRE, M_RND, M_WR, M_ERR} ph_t;
  ph_t ph;
  int kbits, w_in, w_out, rnd;
  logic key_ok, mdec, mopt, pend;
  int n_ks = 0, n_lk = 0, n_dck = 0, n_re = 0, n_wr = 0, n_blk = 0, n_pab = 0;
  int pre_idx = -1, first_idx = -1, last_idx = -1;
  logic prev_pre = 1'b0, prev_blk = 1'b0;
  logic [12:0] s_outs;
  logic [CNT_W-1:0] s_idx;
  function automatic int nr();
    return 6 + kbits / 32;
  endfunction
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mreset();
    ph = M_IDLE; kbits = 128; w_in = 0; w_out = 0; rnd = 0;
    key_ok = 0; mdec = 0; mopt = 0; pend = 0;
  endtask
  task automatic tick();
    logic [12:0] e;
    int ei;
    @(negedge clk);
    ei = ph == M_PRE ? (enc_dec ? nr() : 0) : ph == M_RND ? (mdec ? nr() - rnd : rnd) : 0;
    e = {ph == M_PRE ? enc_dec : mopt, ph == M_KE && !key_done, ph == M_KF && data_received && data_type,
         ph == M_PRE, ph == M_PRE, ph == M_RND, ph == M_RND && rnd == nr(), ph == M_WR,
         ph == M_WR ? out_ready : (data_received && !data_type && (ph == M_DF || (ph == M_RND && !pend))),
         ph == M_KE && key_done, ph == M_WR && out_ready && w_out == WORDS - 1,
         ph != M_IDLE && ph != M_ERR, ph == M_ERR};
    check("outs", outs, e);
    check("round_idx", round_idx, ei);
    n_ks += key_shift_en; n_lk += load_key; n_dck += done_chg_key;
    n_re += round_en; n_wr += ahb_mode; n_blk += blk_done;
    if (preaddkey) pre_idx = round_idx;
    if (round_en && prev_pre) first_idx = round_idx;
    if (last_round) last_idx = round_idx;
    if (preaddkey && prev_blk) n_pab++;
    prev_pre = preaddkey; prev_blk = blk_done; s_outs = outs; s_idx = round_idx;
    if (rst) mreset();
    else case (ph)
      M_IDLE: begin
        w_in = 0; w_out = 0; pend = 0;
        if (start) begin
          if (data_type) begin
            if (key_len != 2'b11) begin kbits = 128 + 64 * key_len; ph = M_KF; end
            else ph = M_ERR;
          end else ph = key_ok ? M_DF : M_ERR;
        end
      end
      M_KF: if (data_received) begin
        if (!data_type) ph = M_ERR;
        else begin w_in++; if (w_in == kbits / 32) begin w_in = 0; ph = M_KE; end end
      end
      M_KE: if (key_done) begin key_ok = 1; ph = M_IDLE; end
      M_DF: if (data_received) begin
        if (data_type) ph = M_ERR;
        else begin w_in++; if (w_in == WORDS) begin w_in = 0; ph = M_PRE; end end
      end else if (stop && w_in == 0) ph = M_IDLE;
      M_PRE: begin mdec = enc_dec; mopt = enc_dec; rnd = 1; ph = M_RND; end
      M_RND: if (data_received && data_type) ph = M_ERR;
      else begin
        if (data_received && !pend) begin w_in++; if (w_in == WORDS) begin w_in = 0; pend = 1; end end
        if (rnd == nr()) ph = M_WR; else rnd++;
      end
      M_WR: if (out_ready) begin
        w_out++;
        if (w_out == WORDS) begin w_out = 0; ph = pend ? M_PRE : M_DF; pend = 0; end
      end
      M_ERR: if (start) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    @(posedge clk); #1;
  endtask
  task automatic cyc(input logic s, input logic dr, input logic dt, input int n);
    start = s; data_received = dr; data_type = dt;
    repeat (n) tick();
  endtask
  task automatic load(input logic [1:0] kl);
    key_len = kl; key_done = 0;
    cyc(1, 0, 1, 1);
    cyc(0, 1, 1, 4 + 2 * kl);
    cyc(0, 0, 0, 3);
    key_done = 1;
    cyc(0, 0, 0, 1);
    key_done = 0;
  endtask
  initial begin
    int a, b, c, d;
    rst = 1; start = 0; data_received = 0; data_type = 0; enc_dec = 0;
    key_len = 0; key_done = 0; out_ready = 0; stop = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    mreset();
    cyc(0, 0, 0, 1);
    rst = 0;
    cyc(0, 0, 0, 1);
    check("reset_outs", s_outs, 0);
    check("reset_idx", s_idx, 0);
    a = n_ks; b = n_lk; c = n_dck;
    load(2'b00);
    check("key128_shifts", n_ks - a, 4);
    check("key128_load_key", n_lk - b, 3);
    check("key128_done_chg", n_dck - c, 1);
    cyc(0, 0, 0, 1);
    check("idle_after_key", s_outs, 0);
    enc_dec = 0; out_ready = 1;
    a = n_re; b = n_wr; c = n_blk;
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 15);
    check("enc_pre_idx", pre_idx, 0);
    check("enc_first_idx", first_idx, 1);
    check("enc_last_idx", last_idx, 10);
    check("enc_rounds", n_re - a, 10);
    check("enc_writes", n_wr - b, 4);
    check("enc_blk_done", n_blk - c, 1);
    stop = 1;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    check("stop_ignored_busy", s_outs[1], 1);
    stop = 0;
    cyc(0, 1, 0, 3);
    cyc(0, 0, 0, 15);
    stop = 1;
    cyc(0, 0, 0, 1);
    stop = 0;
    cyc(0, 0, 0, 1);
    check("stop_to_idle", s_outs[1], 0);
    load(2'b10);
    enc_dec = 1; out_ready = 0;
    a = n_re;
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 10);
    check("dec_pre_idx", pre_idx, 14);
    check("dec_first_idx", first_idx, 13);
    check("dec_last_idx", last_idx, 0);
    check("dec_rounds", n_re - a, 14);
    b = n_wr; c = n_blk; d = n_pab;
    out_ready = 1; cyc(0, 0, 0, 1);
    out_ready = 0; cyc(0, 0, 0, 3);
    out_ready = 1; cyc(0, 0, 0, 3);
    check("stretched_write", n_wr - b, 7);
    cyc(0, 0, 0, 1);
    check("straight_to_preadd", n_pab - d, 1);
    cyc(0, 0, 0, 18);
    check("two_blocks_done", n_blk - c, 2);
    stop = 1; cyc(0, 0, 0, 1); stop = 0;
    a = n_ks;
    load(2'b01);
    check("key192_shifts", n_ks - a, 6);
    rst = 1; cyc(0, 0, 0, 1); rst = 0;
    enc_dec = 0;
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("err_no_key", s_outs[0], 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("err_cleared", s_outs[1:0], 0);
    key_len = 2'b11;
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 1);
    check("err_bad_keylen", s_outs[0], 1);
    load(2'b00);
    cyc(1, 0, 1, 1);
    cyc(0, 1, 1, 2);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    check("err_data_in_keyfetch", s_outs[0], 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 0, 1);
    check("err_key_mid_block", s_outs[0], 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("key_valid_kept", s_outs[1:0], 2);
    cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 5);
    c = n_blk;
    rst = 1;
    cyc(0, 0, 0, 1);
    check("round5_idx", s_idx, 5);
    rst = 0;
    cyc(0, 0, 0, 1);
    check("rst_mid_round_outs", s_outs, 0);
    check("rst_mid_round_idx", s_idx, 0);
    out_ready = 1;
    cyc(0, 0, 0, 20);
    check("no_blk_after_rst", n_blk - c, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_seq_ctrl.md
AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning 32-bit bus words per cipher block (range 2..8).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of all internal word and round counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, CPU job request from the AHB-lite interface.
REQ-006 SHALL have port data_received, input, 1, one bus word is present this cycle.
REQ-007 SHALL have port data_type, input, 1, 1 = key word, 0 = data word.
REQ-008 SHALL have port enc_dec, input, 1, 0 = encrypt, 1 = decrypt; sampled at block start.
REQ-009 SHALL have port key_len, input, 2, 00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = illegal.
REQ-010 SHALL have port key_done, input, 1, key expansion finished (from GenKey).
REQ-011 SHALL have port out_ready, input, 1, interface accepts an output word this cycle.
REQ-012 SHALL have port stop, input, 1, end-of-stream request.
REQ-013 SHALL have output ports opt_mode, load_key, key_shift_en, preaddkey, aes_load, round_en, last_round, ahb_mode, ahb_shift_en, done_chg_key, blk_done, busy and error, each 1 bit.
REQ-014 SHALL have output port round_idx, CNT_W bits, round-key index for the current round.

Function
REQ-015 SHALL implement states IDLE, KEY_FETCH, KEY_EXPAND, DATA_FETCH, PREADD, ROUND, WRITE and ERROR.
REQ-016 IDLE: on start with data_type=1, SHALL latch key_len and go to KEY_FETCH; key_len=11 SHALL go to ERROR instead.
REQ-017 IDLE: on start with data_type=0, SHALL go to DATA_FETCH if key_valid=1, else to ERROR.
REQ-018 KEY_FETCH: each data_received cycle SHALL assert key_shift_en in the same cycle; after Nk words (4/6/8) SHALL go to KEY_EXPAND.
REQ-019 KEY_EXPAND: SHALL hold load_key=1 until key_done, then pulse done_chg_key for 1 cycle, set key_valid and return to IDLE.
REQ-020 DATA_FETCH: each data_received cycle SHALL assert ahb_shift_en combinationally with ahb_mode=0 and increment in_cnt.
REQ-021 DATA_FETCH: when word WORDS is accepted, SHALL clear in_cnt and go to PREADD.
REQ-022 PREADD: SHALL last exactly 1 cycle, assert preaddkey and aes_load, latch opt_mode from enc_dec, and drive round_idx = 0 (encrypt) or Nr (decrypt).
REQ-023 ROUND: SHALL assert round_en for exactly Nr cycles (Nr = 10/12/14 per latched key_len).
REQ-024 ROUND: round_idx SHALL step +1 per cycle for encrypt or -1 for decrypt.
REQ-025 ROUND: last_round SHALL assert on the final round cycle only; the next state SHALL be WRITE.
REQ-026 ROUND: data words arriving during ROUND SHALL be accepted (ahb_shift_en, ahb_mode=0) into in_cnt; reaching WORDS SHALL set nxt_valid and stop further acceptance.
REQ-027 WRITE: SHALL drive ahb_mode=1 and ahb_shift_en=out_ready, counting accepted words.
REQ-028 WRITE: after WORDS words, SHALL pulse blk_done for 1 cycle and go to PREADD if nxt_valid (clearing nxt_valid), otherwise to DATA_FETCH.
REQ-029 DATA_FETCH with in_cnt=0 and stop=1 SHALL go to IDLE; stop in any other state SHALL be ignored until that condition holds.
REQ-030 A key word (data_type=1 with data_received) in DATA_FETCH or ROUND SHALL go to ERROR.
REQ-031 A data word arriving in KEY_FETCH SHALL go to ERROR.
REQ-032 ERROR: SHALL assert error; start SHALL return the block to IDLE with key_valid preserved.
REQ-033 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-034 Every strobe output SHALL be 0 in any state not listed as driving it.
REQ-035 Simultaneous data_received and stop in DATA_FETCH with in_cnt=0: the word SHALL be accepted and stop ignored.

Reset
REQ-036 rst=1 SHALL force IDLE on the next edge and clear in_cnt, out_cnt, round counter, nxt_valid, key_valid and latched modes.
REQ-037 After reset every output SHALL be 0, including round_idx.
REQ-038 Reset asserted mid-ROUND or mid-WRITE SHALL abort without emitting blk_done.

Structure
REQ-039 Package aes_ctrl_pkg SHALL hold the state enum, the key_len codes and the Nk/Nr lookup functions.
REQ-040 The word and round counters SHALL each instantiate flex_counter; no other sub-modules.

Verification
REQ-041 Reset, key_len=00, 4 key words -> 4 key_shift_en; load_key held until key_done; 1-cycle done_chg_key; then IDLE.
REQ-042 With a 128-bit key, encrypt: 4 data words -> PREADD round_idx=0, 10 round_en cycles with round_idx 1..10, last_round on idx 10, 4 writes, blk_done.
REQ-043 256-bit key, decrypt -> PREADD round_idx=14, 14 rounds counting 13..0, last_round at idx 0.
REQ-044 Next block streamed during ROUND -> after WRITE goes straight to PREADD with no DATA_FETCH cycles; out_ready low 3 cycles mid-WRITE stretches WRITE by 3.
REQ-045 Data start with key_valid=0 -> ERROR with error=1; start -> IDLE; key word mid-block -> ERROR.
REQ-046 rst pulse during round 5 -> all outputs 0 next cycle; no blk_done.
